// File: rtl/rs_encode_pkg.sv
// Shared RS encoder types: symbol width, serializer FSM state encoding and beat-count width helper.
package rs_encode_pkg;

  localparam int unsigned RS_WORD_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LINE = 2'd1,
    DRAIN     = 2'd2
  } rs_ser_state_e;

  // Width of a symbol count that must represent 0..out_syms inclusive.
  function automatic int unsigned RS_SYM_CNT_W(input int unsigned out_syms);
    return $clog2(out_syms + 1);
  endfunction

endpackage

// File: rtl/rs_encode_line_sym_mux.sv
// Picks cnt symbols starting at byte_off from a line, lane 0 in the MS bits, unused lanes zeroed.
module rs_encode_line_sym_mux
  import rs_encode_pkg::*;
#(
  parameter int unsigned DATA_W   = 512,
  parameter int unsigned OUT_SYMS = 4,
  parameter int unsigned BOFF_W   = 6,
  parameter int unsigned CNT_W    = 3
) (
  input  logic [DATA_W-1:0]             line,
  input  logic [BOFF_W-1:0]             byte_off,
  input  logic [CNT_W-1:0]              cnt,
  output logic [OUT_SYMS*RS_WORD_W-1:0] lanes
);

  logic [DATA_W-1:0] shifted;

  always_comb begin
    shifted = line << (32'(byte_off) * RS_WORD_W);
    lanes   = '0;
    for (int i = 0; i < int'(OUT_SYMS); i++) begin
      if (32'(i) < 32'(cnt)) begin
        lanes[OUT_SYMS*RS_WORD_W-1-i*RS_WORD_W -: RS_WORD_W] =
          shifted[DATA_W-1-i*RS_WORD_W -: RS_WORD_W];
      end
    end
  end

endmodule

// File: rtl/rs_encode_line_serializer.sv
// Splits run-time-length messages from wide lines into OUT_SYMS-symbol beats for the RS core.
// Define RS_LINE_SER_PREFETCH_EN to add a prefetch line register for bubble-free line changes.
module rs_encode_line_serializer
  import rs_encode_pkg::*;
#(
  parameter int unsigned DATA_W        = 512,
  parameter int unsigned OUT_SYMS      = 4,
  parameter int unsigned MAX_MSG_BYTES = 223,
  parameter int unsigned MSG_LEN_W     = $clog2(MAX_MSG_BYTES + 1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cmd_val,
  output logic                                cmd_rdy,
  input  logic [MSG_LEN_W-1:0]                cmd_msg_bytes,
  input  logic                                src_line_val,
  output logic                                src_line_rdy,
  input  logic [DATA_W-1:0]                   src_line_data,
  output logic                                out_val,
  input  logic                                out_rdy,
  output logic [OUT_SYMS*RS_WORD_W-1:0]       out_data,
  output logic [RS_SYM_CNT_W(OUT_SYMS)-1:0]   out_sym_cnt,
  output logic                                out_last,
  output logic                                busy
);

  localparam int unsigned DATA_BYTES = DATA_W / RS_WORD_W;
  localparam int unsigned BOFF_W     = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam int unsigned CNT_W      = RS_SYM_CNT_W(OUT_SYMS);
  localparam int unsigned OUT_W      = OUT_SYMS * RS_WORD_W;

  localparam logic [1:0] ST_IDLE      = 2'(IDLE);
  localparam logic [1:0] ST_WAIT_LINE = 2'(WAIT_LINE);
  localparam logic [1:0] ST_DRAIN     = 2'(DRAIN);

  if (DATA_W % RS_WORD_W != 0) begin : g_bad_data_w
    $error("DATA_W must be a multiple of RS_WORD_W");
  end
  if (DATA_BYTES % OUT_SYMS != 0) begin : g_bad_out_syms
    $error("symbols per line must be a multiple of OUT_SYMS");
  end

  logic [1:0]           state, nxt_state;
  logic [DATA_W-1:0]    line_q, nxt_line;
  logic [BOFF_W-1:0]    byte_off, nxt_off;
  logic [MSG_LEN_W-1:0] bytes_left, nxt_left;
  logic [BOFF_W:0]      sent_off;
  logic [CNT_W-1:0]     nxt_cnt;
  logic [OUT_W-1:0]     nxt_data;
  logic                 nxt_last, nxt_src_rdy;
  logic                 cmd_fire, line_fire, out_fire;
`ifdef RS_LINE_SER_PREFETCH_EN
  logic [DATA_W-1:0]    pf_line, nxt_pf_line;
  logic                 pf_full, nxt_pf_full;
`endif

  assign cmd_fire  = cmd_val & cmd_rdy;
  assign line_fire = src_line_val & src_line_rdy;
  assign out_fire  = out_val & out_rdy;

  // Symbols available for the next beat: bounded by lane count, message and line remainder.
  function automatic logic [CNT_W-1:0] beat_cnt(input logic [MSG_LEN_W-1:0] left,
                                                input logic [BOFF_W-1:0]    off);
    int unsigned n;
    n = OUT_SYMS;
    if (32'(left) < n) n = 32'(left);
    if (DATA_BYTES - 32'(off) < n) n = DATA_BYTES - 32'(off);
    return CNT_W'(n);
  endfunction

  always_comb begin
    nxt_state = state;
    nxt_line  = line_q;
    nxt_off   = byte_off;
    nxt_left  = bytes_left;
`ifdef RS_LINE_SER_PREFETCH_EN
    nxt_pf_line = pf_line;
    nxt_pf_full = pf_full;
`endif
    sent_off = {1'b0, byte_off} + (BOFF_W+1)'(out_sym_cnt);

    case (state)
      ST_IDLE: begin
        if (cmd_fire && (cmd_msg_bytes != '0)) begin
          nxt_left  = (32'(cmd_msg_bytes) > MAX_MSG_BYTES) ? MSG_LEN_W'(MAX_MSG_BYTES)
                                                           : cmd_msg_bytes;
          nxt_state = ST_WAIT_LINE;
        end
      end
      ST_WAIT_LINE: begin
        if (line_fire) begin
          nxt_line  = src_line_data;
          nxt_off   = '0;
          nxt_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
`ifdef RS_LINE_SER_PREFETCH_EN
        if (line_fire) begin
          nxt_pf_line = src_line_data;
          nxt_pf_full = 1'b1;
        end
`endif
        if (out_fire) begin
          nxt_left = bytes_left - MSG_LEN_W'(out_sym_cnt);
          if (out_last) begin
            nxt_state = ST_IDLE;
          end else if (sent_off >= (BOFF_W+1)'(DATA_BYTES)) begin
            nxt_off = '0;
`ifdef RS_LINE_SER_PREFETCH_EN
            // A line arriving on the very cycle the current one ends goes straight to line_q.
            if (pf_full) begin
              nxt_line    = pf_line;
              nxt_pf_full = 1'b0;
            end else if (line_fire) begin
              nxt_line    = src_line_data;
              nxt_pf_full = 1'b0;
            end else begin
              nxt_state = ST_WAIT_LINE;
            end
`else
            nxt_state = ST_WAIT_LINE;
`endif
          end else begin
            nxt_off = BOFF_W'(sent_off);
          end
        end
      end
      default: nxt_state = ST_IDLE;
    endcase

    // Output registers are loaded from the next-state view so beats appear with no extra delay.
    nxt_cnt     = (nxt_state == ST_DRAIN) ? beat_cnt(nxt_left, nxt_off) : '0;
    nxt_last    = (nxt_state == ST_DRAIN) && (32'(nxt_cnt) == 32'(nxt_left));
    nxt_src_rdy = (nxt_state == ST_WAIT_LINE);
`ifdef RS_LINE_SER_PREFETCH_EN
    if ((nxt_state == ST_DRAIN) && !nxt_pf_full &&
        (32'(nxt_left) > DATA_BYTES - 32'(nxt_off))) begin
      nxt_src_rdy = 1'b1;
    end
`endif
  end

  rs_encode_line_sym_mux #(
    .DATA_W   (DATA_W),
    .OUT_SYMS (OUT_SYMS),
    .BOFF_W   (BOFF_W),
    .CNT_W    (CNT_W)
  ) u_sym_mux (
    .line     (nxt_line),
    .byte_off (nxt_off),
    .cnt      (nxt_cnt),
    .lanes    (nxt_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      line_q       <= '0;
      byte_off     <= '0;
      bytes_left   <= '0;
      cmd_rdy      <= 1'b1;
      src_line_rdy <= 1'b0;
      out_val      <= 1'b0;
      out_data     <= '0;
      out_sym_cnt  <= '0;
      out_last     <= 1'b0;
      busy         <= 1'b0;
`ifdef RS_LINE_SER_PREFETCH_EN
      pf_line      <= '0;
      pf_full      <= 1'b0;
`endif
    end else begin
      state        <= nxt_state;
      line_q       <= nxt_line;
      byte_off     <= nxt_off;
      bytes_left   <= nxt_left;
      cmd_rdy      <= (nxt_state == ST_IDLE);
      src_line_rdy <= nxt_src_rdy;
      out_val      <= (nxt_state == ST_DRAIN);
      out_data     <= nxt_data;
      out_sym_cnt  <= nxt_cnt;
      out_last     <= nxt_last;
      busy         <= (nxt_state != ST_IDLE);
`ifdef RS_LINE_SER_PREFETCH_EN
      pf_line      <= nxt_pf_line;
      pf_full      <= nxt_pf_full;
`endif
    end
  end

endmodule

// File: tb/tb_rs_encode_line_serializer.sv
// Randomized self-checking bench for rs_encode_line_serializer against a message-level beat model.
module tb_rs_encode_line_serializer;

  localparam int unsigned DATA_W        = 512;
  localparam int unsigned OUT_SYMS      = 4;
  localparam int unsigned MAX_MSG_BYTES = 223;
  localparam int unsigned MSG_LEN_W     = $clog2(MAX_MSG_BYTES + 1);
  localparam int unsigned DATA_BYTES    = DATA_W / 8;
  localparam int unsigned CNT_W         = $clog2(OUT_SYMS + 1);
  localparam int unsigned OUT_W         = OUT_SYMS * 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 cmd_val;
  logic                 cmd_rdy;
  logic [MSG_LEN_W-1:0] cmd_msg_bytes;
  logic                 src_line_val;
  logic                 src_line_rdy;
  logic [DATA_W-1:0]    src_line_data;
  logic                 out_val;
  logic                 out_rdy;
  logic [OUT_W-1:0]     out_data;
  logic [CNT_W-1:0]     out_sym_cnt;
  logic                 out_last;
  logic                 busy;

  rs_encode_line_serializer #(
    .DATA_W        (DATA_W),
    .OUT_SYMS      (OUT_SYMS),
    .MAX_MSG_BYTES (MAX_MSG_BYTES),
    .MSG_LEN_W     (MSG_LEN_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_val       (cmd_val),
    .cmd_rdy       (cmd_rdy),
    .cmd_msg_bytes (cmd_msg_bytes),
    .src_line_val  (src_line_val),
    .src_line_rdy  (src_line_rdy),
    .src_line_data (src_line_data),
    .out_val       (out_val),
    .out_rdy       (out_rdy),
    .out_data      (out_data),
    .out_sym_cnt   (out_sym_cnt),
    .out_last      (out_last),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OUT_W-1:0] data;
    int unsigned      cnt;
    logic             last;
  } beat_t;

  beat_t       exp_q[$];
  int unsigned n_vec = 0, n_err = 0;
  int unsigned line_idx, lines_offered, stall_pct;
  int unsigned n_busy, n_valc, n_beats;
  logic        cmd_fired;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Message byte i carries value i mod 256.
  function automatic logic [DATA_W-1:0] line_data(input int unsigned idx);
    logic [DATA_W-1:0] d;
    for (int unsigned j = 0; j < DATA_BYTES; j++)
      d[DATA_W-1-8*j -: 8] = 8'((idx * DATA_BYTES + j) % 256);
    return d;
  endfunction

  // Expected beats: each line's in-message bytes chopped into groups of OUT_SYMS.
  function automatic void build_expected(input int unsigned len);
    int unsigned l;
    l = (len > MAX_MSG_BYTES) ? MAX_MSG_BYTES : len;
    exp_q.delete();
    for (int unsigned ln = 0; ln * DATA_BYTES < l; ln++) begin
      int unsigned in_line;
      in_line = (l - ln * DATA_BYTES < DATA_BYTES) ? l - ln * DATA_BYTES : DATA_BYTES;
      for (int unsigned o = 0; o < in_line; o += OUT_SYMS) begin
        beat_t       b;
        int unsigned n;
        n = (in_line - o < OUT_SYMS) ? in_line - o : OUT_SYMS;
        b.data = '0;
        b.cnt  = n;
        for (int unsigned k = 0; k < n; k++)
          b.data[OUT_W-1-8*k -: 8] = 8'((ln * DATA_BYTES + o + k) % 256);
        b.last = (ln * DATA_BYTES + o + n == l);
        exp_q.push_back(b);
      end
    end
  endfunction

  // One clock: check outputs at negedge, then drive inputs for the next posedge.
  task automatic cycle();
    @(negedge clk);
    if (cmd_fired) begin
      cmd_val   = 1'b0;
      cmd_fired = 1'b0;
    end
    if (out_val) begin
      if (exp_q.size() == 0) begin
        check("extra_beat", 64'(out_val), 64'(0));
      end else begin
        check("data", 64'(out_data), 64'(exp_q[0].data));
        check("cnt", 64'(out_sym_cnt), 64'(exp_q[0].cnt));
        check("last", 64'(out_last), 64'(exp_q[0].last));
      end
    end
    if (busy) n_busy++;
    if (out_val) n_valc++;
    out_rdy = ($urandom_range(99) >= stall_pct);
    if (out_val && out_rdy && exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      n_beats++;
    end
    src_line_val  = (line_idx < lines_offered);
    src_line_data = line_data(line_idx);
    if (src_line_val && src_line_rdy) line_idx++;
    if (cmd_val && cmd_rdy) cmd_fired = 1'b1;
  endtask

  // Offers one more line than the message needs, to catch over-acceptance.
  task automatic run_msg(input int unsigned len, input int unsigned stall,
                         input int unsigned stop_after);
    int unsigned l, budget, need;
    l      = (len > MAX_MSG_BYTES) ? MAX_MSG_BYTES : len;
    need   = (l + DATA_BYTES - 1) / DATA_BYTES;
    budget = 3000;
    build_expected(len);
    line_idx      = 0;
    lines_offered = need + 1;
    n_busy        = 0;
    n_valc        = 0;
    n_beats       = 0;
    stall_pct     = stall;
    src_line_val  = 1'b1;
    src_line_data = line_data(0);
    cmd_msg_bytes = MSG_LEN_W'(len);
    cmd_val       = 1'b1;
    cmd_fired     = cmd_rdy;
    cycle();
    while ((exp_q.size() != 0 || busy || cmd_val) && budget != 0 &&
           !(stop_after != 0 && n_beats >= stop_after)) begin
      cycle();
      budget--;
    end
    if (budget == 0) check("timeout", 64'(exp_q.size()), 64'(0));
    if (stop_after == 0) begin
      repeat (3) cycle();
      check("lines_taken", 64'(line_idx), 64'(need));
    end
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    cmd_val      = 1'b0;
    cmd_fired    = 1'b0;
    src_line_val = 1'b0;
    out_rdy      = 1'b0;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    check("rst_cmd_rdy", 64'(cmd_rdy), 64'(1));
    check("rst_src_rdy", 64'(src_line_rdy), 64'(0));
    check("rst_out_val", 64'(out_val), 64'(0));
    check("rst_out_last", 64'(out_last), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_sym_cnt", 64'(out_sym_cnt), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_val", 64'(out_val), 64'(0));
    check("post_rst_cmd_rdy", 64'(cmd_rdy), 64'(1));
  endtask

  initial begin
    rst           = 1'b1;
    cmd_val       = 1'b0;
    cmd_msg_bytes = '0;
    src_line_val  = 1'b0;
    src_line_data = '0;
    out_rdy       = 1'b0;
    cmd_fired     = 1'b0;
    line_idx      = 0;
    lines_offered = 0;
    stall_pct     = 0;
    do_reset();

    // Full-length message, unstalled; also checks cycle cost per line.
    run_msg(223, 0, 0);
    check("t1_beats", 64'(n_beats), 64'(56));
    check("t1_val_cycles", 64'(n_valc), 64'(56));
`ifdef RS_LINE_SER_PREFETCH_EN
    check("t1_busy_cycles", 64'(n_busy), 64'(57));
`else
    check("t1_busy_cycles", 64'(n_busy), 64'(60));
`endif

    // Exactly one line.
    run_msg(64, 0, 0);
    check("t2_beats", 64'(n_beats), 64'(16));
    check("t2_busy", 64'(busy), 64'(0));
    check("t2_src_rdy", 64'(src_line_rdy), 64'(0));
    check("t2_cmd_rdy", 64'(cmd_rdy), 64'(1));

    // Zero length is swallowed, then a short message.
    run_msg(0, 0, 0);
    check("t3_zero_beats", 64'(n_beats), 64'(0));
    check("t3_zero_busy", 64'(n_busy), 64'(0));
    run_msg(5, 0, 0);
    check("t3_beats", 64'(n_beats), 64'(2));

    // Backpressure.
    run_msg(200, 30, 0);
    check("t4_beats", 64'(n_beats), 64'(50));

    // Over-length request is clamped.
    run_msg(250, 10, 0);
    check("clamp_beats", 64'(n_beats), 64'(56));

    // Random lengths and stall rates.
    for (int r = 0; r < 8; r++)
      run_msg($urandom_range(MAX_MSG_BYTES, 1), $urandom_range(50, 0), 0);

    // Reset in the middle of a message, then recovery.
    run_msg(223, 0, 10);
    do_reset();
    run_msg(10, 0, 0);
    check("t5_beats", 64'(n_beats), 64'(3));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
